aer_fifo_reader: RTL and testbench



---
 rtl/aer_fifo_reader.sv | 114 +++++++++++
 tb/tb_aer_fifo_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_fifo_reader.sv
// Read-side consumer for the FWFT event FIFO: pops DWIDTH-bit AER words and
// serializes each into BEATS OWIDTH-bit beats on a valid/ready stream.
module aer_fifo_reader #(
    parameter int DWIDTH = 64,
    parameter int OWIDTH = 16,
    parameter int DEPTH  = 64,
    localparam int AWIDTH = $clog2(DEPTH),
    localparam int BEATS  = DWIDTH / OWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        burst_len,
    input  logic              abort,
    input  logic              fifo_empty,
    input  logic [AWIDTH:0]   fifo_numel,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       words_sent
);

    localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t            state;
    logic [8:0]        remaining;
    logic [BCW-1:0]    beat_cnt;
    logic [DWIDTH-1:0] shreg;

    logic [8:0] start_len;
    logic       last_hs;
    logic       more;

    always_comb begin
        start_len = (burst_len == 8'd0) ? 9'(fifo_numel) : {1'b0, burst_len};
        last_hs   = (state == SEND) && out_ready && (beat_cnt == LAST_BEAT);
        more      = remaining > 9'd1;
    end

    // Pop either from LOAD or on the final beat of a word (no-bubble reload);
    // abort suppresses any pop in its cycle.
    assign fifo_rd_en = !abort && !fifo_empty &&
                        ((state == LOAD) || (last_hs && more));

    assign out_valid = (state == SEND);
    assign out_data  = shreg[OWIDTH-1:0];
    assign out_last  = (state == SEND) && (beat_cnt == LAST_BEAT) && (remaining == 9'd1);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            beat_cnt   <= '0;
            shreg      <= '0;
            words_sent <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= start_len;
                        state     <= (start_len == 9'd0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= DONE;
                    end else if (fifo_rd_en) begin
                        shreg    <= fifo_rdata;
                        beat_cnt <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state <= DONE;
                    end else if (out_ready) begin
                        if (beat_cnt != LAST_BEAT) begin
                            shreg    <= shreg >> OWIDTH;
                            beat_cnt <= beat_cnt + 1'b1;
                        end else begin
                            remaining  <= remaining - 9'd1;
                            words_sent <= words_sent + 16'd1;
                            if (fifo_rd_en) begin
                                shreg    <= fifo_rdata;
                                beat_cnt <= '0;
                            end else if (more) begin
                                state <= LOAD;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aer_fifo_reader.sv
// Bench for aer_fifo_reader: a queue models the FWFT FIFO, bursts are driven
// from a vector table, and abort/reset corners are hand-sequenced.
module tb_aer_fifo_reader;

    localparam int DW    = 64;
    localparam int OW    = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int BEATS = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    burst_len;
    logic          abort;
    logic          fifo_empty;
    logic [AW:0]   fifo_numel;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rd_en;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [15:0]   words_sent;

    aer_fifo_reader #(.DWIDTH(DW), .OWIDTH(OW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .abort(abort),
        .fifo_empty(fifo_empty), .fifo_numel(fifo_numel), .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .words_sent(words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned npre;      // words preloaded
        logic [7:0]  blen;
        bit          toggle;    // out_ready = even cycle index
        int unsigned inject_at; // cycle at which one extra word is written (0 = none)
        bit          contig;    // reloads expected on the last beat of each word
        int unsigned exp_pops;
        int unsigned exp_valid;
        int unsigned exp_busy;  // also the cycle index of the done pulse
        int unsigned exp_left;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] all_words[$];
    logic [OW-1:0] got_data[$];
    bit            got_last[$];
    int            beat_cyc[$];
    int            pop_cyc[$];
    int            cyc, pops_n, busy_n, done_n, done_cyc, valid_n;
    bit            prev_stall;
    logic [OW-1:0] prev_data;
    bit            prev_last;
    int unsigned   exp_ws = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] gen(input int idx, input int i);
        return 64'h1122334455667788 + 64'(idx * 16 + i) * 64'h0001000100010001;
    endfunction

    task automatic update_fifo();
        fifo_empty = (q.size() == 0);
        fifo_numel = (AW+1)'(q.size());
        fifo_rdata = (q.size() == 0) ? '0 : q[0];
    endtask

    task automatic clear_mon();
        got_data.delete(); got_last.delete(); beat_cyc.delete(); pop_cyc.delete();
        cyc = 0; pops_n = 0; busy_n = 0; done_n = 0; done_cyc = -1; valid_n = 0;
        prev_stall = 0;
    endtask

    // Samples one cycle mid-period, then advances past the next rising edge.
    task automatic tick();
        logic          pop;
        logic [DW-1:0] tmp;
        #1;
        if (prev_stall)
            check("hold_stable", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
        if (fifo_rd_en) begin
            pops_n++;
            pop_cyc.push_back(cyc);
            check("pop_only_nonempty", fifo_empty, 0);
        end
        if (busy) busy_n++;
        if (done) begin done_n++; done_cyc = cyc; end
        if (out_valid) valid_n++;
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            beat_cyc.push_back(cyc);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        pop = fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop && q.size() > 0) tmp = q.pop_front();
        update_fifo();
        cyc++;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit            seen;
        logic [DW-1:0] w;
        int            nb;
        q.delete(); all_words.delete();
        for (int unsigned i = 0; i < v.npre; i++) begin
            w = gen(idx, int'(i));
            q.push_back(w); all_words.push_back(w);
        end
        update_fifo();
        clear_mon();
        burst_len = v.blen; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        while (!seen && cyc < 100) begin
            out_ready = v.toggle ? (cyc % 2 == 0) : 1'b1;
            if (v.inject_at != 0 && cyc == int'(v.inject_at)) begin
                w = gen(idx, int'(v.npre));
                q.push_back(w); all_words.push_back(w);
                update_fifo();
            end
            tick();
            seen = (done_n > 0);
        end
        out_ready = 1'b1;
        #1;
        check($sformatf("v%0d_done_seen", idx), seen, 1);
        check($sformatf("v%0d_idle_after", idx), {busy, done, out_valid}, 3'b000);
        check($sformatf("v%0d_pops", idx), pops_n, v.exp_pops);
        check($sformatf("v%0d_valid_cycles", idx), valid_n, v.exp_valid);
        check($sformatf("v%0d_busy_cycles", idx), busy_n, v.exp_busy);
        check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_busy);
        check($sformatf("v%0d_fifo_left", idx), q.size(), v.exp_left);
        exp_ws += v.exp_pops;
        check($sformatf("v%0d_words_sent", idx), words_sent, 16'(exp_ws));
        nb = int'(v.exp_pops) * BEATS;
        check($sformatf("v%0d_beats", idx), got_data.size(), nb);
        for (int k = 0; k < nb && k < got_data.size(); k++) begin
            w = all_words[k / BEATS] >> (OW * (k % BEATS));
            check($sformatf("v%0d_beat%0d", idx, k), {got_last[k], got_data[k]},
                  {(k == nb - 1), w[OW-1:0]});
        end
        if (v.exp_pops > 0 && pop_cyc.size() > 0 && beat_cyc.size() > 0) begin
            check($sformatf("v%0d_first_pop_cyc", idx), pop_cyc[0], 1);
            check($sformatf("v%0d_first_beat_cyc", idx), beat_cyc[0], 2);
        end
        if (v.contig) begin
            for (int k = 1; k < pop_cyc.size() && k * BEATS - 1 < beat_cyc.size(); k++)
                check($sformatf("v%0d_nobubble_pop%0d", idx, k), pop_cyc[k], beat_cyc[k * BEATS - 1]);
        end
    endtask

    task automatic run_abort(input int ac, input int idx);
        q.delete();
        for (int i = 0; i < 2; i++) q.push_back(gen(idx, i));
        update_fifo();
        clear_mon();
        burst_len = 8'd2; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        while (cyc <= ac + 2) begin
            abort = (cyc == ac);
            tick();
        end
        abort = 1'b0;
        check($sformatf("abort%0d_done_cycle", ac), done_cyc, ac + 1);
        check($sformatf("abort%0d_done_count", ac), done_n, 1);
        check($sformatf("abort%0d_pops", ac), pops_n, 1);
        check($sformatf("abort%0d_valid_cycles", ac), valid_n, ac - 1);
        check($sformatf("abort%0d_busy_cycles", ac), busy_n, ac + 1);
        check($sformatf("abort%0d_fifo_left", ac), q.size(), 1);
        check($sformatf("abort%0d_words_sent", ac), words_sent, 16'(exp_ws));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{npre:1, blen:8'd1, toggle:0, inject_at:0, contig:1, exp_pops:1, exp_valid:4,  exp_busy:6,  exp_left:0};
        vecs[1] = '{npre:3, blen:8'd3, toggle:0, inject_at:0, contig:1, exp_pops:3, exp_valid:12, exp_busy:14, exp_left:0};
        vecs[2] = '{npre:2, blen:8'd2, toggle:1, inject_at:0, contig:0, exp_pops:2, exp_valid:15, exp_busy:17, exp_left:0};
        vecs[3] = '{npre:1, blen:8'd2, toggle:0, inject_at:9, contig:0, exp_pops:2, exp_valid:8,  exp_busy:14, exp_left:0};
        vecs[4] = '{npre:5, blen:8'd0, toggle:0, inject_at:0, contig:1, exp_pops:5, exp_valid:20, exp_busy:22, exp_left:0};
        vecs[5] = '{npre:5, blen:8'd0, toggle:0, inject_at:6, contig:1, exp_pops:5, exp_valid:20, exp_busy:22, exp_left:1};
        vecs[6] = '{npre:0, blen:8'd0, toggle:0, inject_at:0, contig:1, exp_pops:0, exp_valid:0,  exp_busy:1,  exp_left:0};
        vecs[7] = '{npre:3, blen:8'd2, toggle:0, inject_at:0, contig:1, exp_pops:2, exp_valid:8,  exp_busy:10, exp_left:1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; burst_len = '0;
        q.delete(); update_fifo(); clear_mon();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_outputs",
              {fifo_rd_en, out_valid, out_data, out_last, busy, done, words_sent},
              '0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        run_abort(3, 8);
        run_abort(5, 9);

        // Reset mid-burst: everything back to reset values, no done pulse.
        q.delete();
        for (int i = 0; i < 2; i++) q.push_back(gen(10, i));
        update_fifo();
        clear_mon();
        burst_len = 8'd2; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        while (cyc <= 3) begin
            rst = (cyc == 3);
            tick();
        end
        rst = 1'b0;
        #1;
        check("rst_outputs",
              {fifo_rd_en, out_valid, out_data, out_last, busy, done, words_sent},
              '0);
        repeat (2) tick();
        check("rst_no_done", done_n, 0);
        check("rst_pops", pops_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
